serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial multi-bit subtractor built around a single full-subtractor cell
//   and a registered borrow. It accepts two WIDTH-bit unsigned operands plus a
//   borrow-in over a valid/ready handshake. It processes one bit per clock,
//   LSB first, and returns the WIDTH-bit difference and borrow-out over a
//   second valid/ready handshake. This is the sequencing stage that feeds the
//   1-bit subtractor cell and collects its diff/borrow outputs.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      a, b, bin valid
//   in_ready   out  1      block can accept an operand set (high only in IDLE)
//   a          in   WIDTH  minuend, unsigned
//   b          in   WIDTH  subtrahend, unsigned
//   bin        in   1      borrow-in
//   out_valid  out  1      diff, bout valid
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout       out  1      1 iff a < b + bin (unsigned)
// BEHAVIOUR
//   - All state updates on the clk rising edge. Reset: rst_n sampled low at an
//     edge forces state=IDLE, out_valid=0, diff=0, bout=0, borrow reg=0, cnt=0.
//   - in_ready = (state==IDLE), decoded combinationally from state. It is high
//     in the first cycle after reset release.
//   - FSM IDLE -> SHIFT -> DONE -> IDLE.
//     IDLE: if in_valid, latch a_sr<=a, b_sr<=b, brw<=bin, cnt<=0; go to SHIFT.
//     SHIFT: each edge computes the cell on (a_sr[0], b_sr[0], brw):
//       d  = a_sr[0]^b_sr[0]^brw
//       bo = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&brw)
//       Then: diff_sr<={d,diff_sr[WIDTH-1:1]}; a_sr,b_sr shift right 1; brw<=bo;
//       cnt<=cnt+1. On the edge where cnt==WIDTH-1, go to DONE.
//     DONE: out_valid=1; diff=diff_sr, bout=brw, held stable. If out_ready is
//       high at an edge, go to IDLE and clear out_valid at that edge.
//   - Latency: out_valid rises exactly WIDTH edges after the accepting edge.
//     Minimum initiation interval is WIDTH+2 cycles, because a new operand set
//     is never accepted in the same cycle a result is consumed.
//   - in_valid outside IDLE is ignored; operand inputs are don't-care there.
//   - No combinational path from in_valid/out_ready to any output except
//     through state.
//   - cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1.
//   - Reset mid-SHIFT or mid-DONE discards the operation. No out_valid pulse
//     follows the reset; the next accepted operand set computes correctly.
//   - Wrap-around: results are modulo 2^WIDTH. Any underflow, including
//     0-0-1, shows as bout=1.
// TESTING (WIDTH=8 unless noted)
//   1. a=0x5A, b=0x23, bin=0 -> diff=0x37, bout=0; out_valid exactly 8 edges
//      after the accepting edge.
//   2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
//      a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
//   3. a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
//      a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
//   4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff/bout/out_valid
//      stay stable, in_ready=0; in_valid pulsed meanwhile is ignored. Raise
//      out_ready -> IDLE the next cycle.
//   5. Drop rst_n for 1 edge after 3 SHIFT cycles -> out_valid never rises;
//      in_ready=1 the next cycle; a following op (a=0x10, b=0x01, bin=0)
//      gives diff=0x0F, bout=0.
//   6. WIDTH=3: all 128 (a, b, bin) combos back-to-back with random out_ready
//      -> every result matches the reference model a-b-bin.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor with valid/ready in and out
//
// Purpose:
//   Computes (a - b - bin) mod 2^WIDTH and the borrow-out one bit per clock,
//   LSB first, through a single full-subtractor cell and a registered borrow.
//   Operands are taken over an input valid/ready handshake; the result is
//   returned over an output valid/ready handshake and held until consumed.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      a, b, bin valid
//   in_ready   out  1      high only while idle
//   a          in   WIDTH  minuend (unsigned)
//   b          in   WIDTH  subtrahend (unsigned)
//   bin        in   1      borrow-in
//   out_valid  out  1      diff, bout valid
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout       out  1      1 iff a < b + bin

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] diff_sr_q;
   logic             brw_q;
   logic [CW-1:0]    cnt_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;

   // Full-subtractor cell on the current LSBs and the running borrow.
   logic             cell_d;
   logic             cell_bo;
   logic [WIDTH-1:0] diff_sr_d;

   assign cell_d    = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
   assign cell_bo   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
   assign diff_sr_d = {cell_d, diff_sr_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         diff_sr_q   <= '0;
         brw_q       <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  brw_q   <= bin;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end

            SHIFT: begin
               diff_sr_q <= diff_sr_d;
               a_sr_q    <= a_sr_q >> 1;
               b_sr_q    <= b_sr_q >> 1;
               brw_q     <= cell_bo;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  // Last bit: capture the completed result straight from the
                  // cell so the outputs are valid on the same edge as out_valid.
                  // cnt returns to zero so it never exceeds WIDTH-1.
                  cnt_q       <= '0;
                  diff_q      <= diff_sr_d;
                  bout_q      <= cell_bo;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end

            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor

module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n;

   // WIDTH=8 instance
   logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8;
   logic [7:0] a8, b8, diff8;

   // WIDTH=3 instance
   logic       in_valid3, in_ready3, bin3, out_valid3, out_ready3, bout3;
   logic [2:0] a3, b3, diff3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .bin       (bin8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .diff      (diff8),
      .bout      (bout8)
   );

   serial_subtractor #(.WIDTH(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .a         (a3),
      .b         (b3),
      .bin       (bin3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .diff      (diff3),
      .bout      (bout3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One WIDTH=8 operation; hold = cycles of backpressure in DONE with
   // in_valid pulsed meanwhile.
   task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi, input int hold);
      int         r;
      int         lat;
      logic [7:0] ed;
      logic       eb;
      r  = int'(av) - int'(bv) - int'(bi);
      ed = r[7:0];
      eb = (r < 0);
      check("in_ready_idle", in_ready8, 1);
      a8 = av; b8 = bv; bin8 = bi; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      lat = 0;
      while (!out_valid8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 8);
      check("diff", diff8, ed);
      check("bout", bout8, eb);
      for (int k = 0; k < hold; k++) begin
         check("bp_in_ready", in_ready8, 0);
         in_valid8 = 1'b1;
         a8 = 8'($urandom); b8 = 8'($urandom);
         @(negedge clk);
         check("bp_out_valid", out_valid8, 1);
         check("bp_diff", diff8, ed);
         check("bp_bout", bout8, eb);
      end
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      check("consumed_out_valid", out_valid8, 0);
      check("consumed_in_ready", in_ready8, 1);
   endtask

   initial begin
      int   r;
      bit   seen;
      bit   got_it;
      logic ordy;

      rst_n = 1'b0;
      in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; bin8 = 0;
      in_valid3 = 0; out_ready3 = 0; a3 = 0; b3 = 0; bin3 = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state, first cycle after release
      check("rst_in_ready8", in_ready8, 1);
      check("rst_out_valid8", out_valid8, 0);
      check("rst_diff8", diff8, 0);
      check("rst_bout8", bout8, 0);
      check("rst_in_ready3", in_ready3, 1);
      check("rst_out_valid3", out_valid3, 0);

      // Directed corner cases
      run_op8(8'h5A, 8'h23, 1'b0, 0);
      run_op8(8'h00, 8'h01, 1'b0, 0);
      run_op8(8'h00, 8'h00, 1'b1, 0);
      run_op8(8'hFF, 8'hFF, 1'b1, 0);
      run_op8(8'hFF, 8'h00, 1'b0, 0);
      // Backpressure for 5 cycles with in_valid pulsed meanwhile
      run_op8(8'hC3, 8'h7E, 1'b1, 5);

      // Reset after 3 SHIFT cycles
      check("pre_rst_in_ready", in_ready8, 1);
      a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_in_ready", in_ready8, 1);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid8) seen = 1'b1;
         @(negedge clk);
      end
      check("mid_rst_no_valid", seen, 0);
      run_op8(8'h10, 8'h01, 1'b0, 0);

      // Random WIDTH=8 operations
      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      // WIDTH=3 exhaustive, back-to-back with random out_ready
      for (int i = 0; i < 128; i++) begin
         logic [2:0] av;
         logic [2:0] bv;
         logic       bi;
         av = 3'(i >> 4);
         bv = 3'(i >> 1);
         bi = 1'(i);
         r  = int'(av) - int'(bv) - int'(bi);
         out_ready3 = 1'b0;
         check("w3_in_ready", in_ready3, 1);
         a3 = av; b3 = bv; bin3 = bi; in_valid3 = 1'b1;
         @(negedge clk);
         in_valid3 = 1'b0;
         got_it = 1'b0;
         for (int k = 0; k < 40 && !got_it; k++) begin
            ordy = 1'($urandom);
            out_ready3 = ordy;
            if (out_valid3 && ordy) begin
               check("w3_diff", diff3, 32'(r & 7));
               check("w3_bout", bout3, (r < 0) ? 1 : 0);
               got_it = 1'b1;
            end
            @(negedge clk);
         end
         if (!got_it) check("w3_timeout", 0, 1);
      end
      out_ready3 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
